design_example_initiator: RTL and testbench

- Initiator and checker for the Start/A/E/F counter datapath-controller pair.
- On a `go` request it issues a one-cycle `start` pulse to the pair, then watches the pair's A, E and F outputs until F rises.
- It captures the final A/E values and the completion latency, and reports pass/fail.
- It sits beside the pair in system and bench tops, so runs can be launched from a host register or a script without hand-driving Start.

---
 rtl/design_example_initiator.sv | 141 ++++++++++++++
 tb/tb_design_example_initiator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/design_example_initiator.sv
// Launches one Start/A/E/F counter-pair run per accepted go, then reports the captured A/E, latency and pass/fail.
// Optional macro CYCLE_CHECK_EN adds a per-cycle A-sequence check and makes latency part of pass.
module design_example_initiator #(
    parameter int         TIMEOUT = 64,
    parameter int         LAT_W   = 8,
    parameter logic [3:0] EXP_A   = 4'b1101,
    parameter logic       EXP_E   = 1'b1,
    parameter int         EXP_LAT = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [3:0]       a_in,
    input  logic             e_in,
    input  logic             f_in,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             f_stuck,
    output logic             seq_err,
    output logic [3:0]       a_cap,
    output logic             e_cap,
    output logic [LAT_W-1:0] lat,
    output logic [7:0]       run_cnt
);

    typedef enum logic [1:0] {IDLE, START, WAIT, FIN} state_t;

    state_t           state;
    logic [LAT_W-1:0] cnt;
    logic             seq_flag;
    logic             lat_ok;

`ifdef CYCLE_CHECK_EN
    logic seq_acc;
    logic seq_bad_now;

    // A must track cnt up to 13 and then hold at 13 until F rises.
    always_comb begin
        seq_bad_now = 1'b0;
        if (state == WAIT && !f_in) begin
            if (cnt < LAT_W'(14))
                seq_bad_now = (a_in != cnt[3:0]);
            else
                seq_bad_now = (a_in != 4'd13);
        end
    end

    assign seq_flag = seq_acc | seq_bad_now;
    assign lat_ok   = (cnt == LAT_W'(EXP_LAT));

    // Sticky mismatch within a run; only published to seq_err on FIN entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            seq_acc <= 1'b0;
        else if (state == START)
            seq_acc <= 1'b0;
        else if (seq_bad_now)
            seq_acc <= 1'b1;
    end
`else
    assign seq_flag = 1'b0;
    assign lat_ok   = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            start   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
            f_stuck <= 1'b0;
            seq_err <= 1'b0;
            a_cap   <= '0;
            e_cap   <= 1'b0;
            lat     <= '0;
            run_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state   <= START;
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        f_stuck <= 1'b0;
                        seq_err <= 1'b0;
                        a_cap   <= '0;
                        e_cap   <= 1'b0;
                        lat     <= '0;
                    end
                end
                START: begin
                    // The pair samples Start on this edge and clears its A and F.
                    state <= WAIT;
                    start <= 1'b0;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (cnt == '0 && f_in) begin
                        state   <= FIN;
                        done    <= 1'b1;
                        run_cnt <= run_cnt + 8'd1;
                        f_stuck <= 1'b1;
                    end else if (f_in) begin
                        state   <= FIN;
                        done    <= 1'b1;
                        run_cnt <= run_cnt + 8'd1;
                        a_cap   <= a_in;
                        e_cap   <= e_in;
                        lat     <= cnt;
                        seq_err <= seq_flag;
                        pass    <= !seq_flag && (a_in == EXP_A) && (e_in == EXP_E) && lat_ok;
                    end else if (cnt == LAT_W'(TIMEOUT - 1)) begin
                        state   <= FIN;
                        done    <= 1'b1;
                        run_cnt <= run_cnt + 8'd1;
                        timeout <= 1'b1;
                        lat     <= LAT_W'(TIMEOUT);
                        seq_err <= seq_flag;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_design_example_initiator.sv
// Directed bench for design_example_initiator with a behavioural Start/A/E/F counter pair.
// Pair modes: 0 nominal, 1 F stuck low, 2 F stuck high, 3 A skips from 4 to 6.
module tb_design_example_initiator;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic [3:0] a_in;
    logic       e_in;
    logic       f_in;
    logic       start, busy, done, pass, timeout, f_stuck, seq_err;
    logic [3:0] a_cap;
    logic       e_cap;
    logic [7:0] lat;
    logic [7:0] run_cnt;

    int errors = 0;
    int checks = 0;
    int mode = 0;
    int j = 200;
    int startCount = 0;
    int edges;
    int s0;
    int nDone;
    logic expSkipPass;
    logic expSkipSeq;

    design_example_initiator #(.TIMEOUT(20)) dut (
        .clock(clock), .reset(reset), .go(go),
        .a_in(a_in), .e_in(e_in), .f_in(f_in),
        .start(start), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .f_stuck(f_stuck), .seq_err(seq_err),
        .a_cap(a_cap), .e_cap(e_cap), .lat(lat), .run_cnt(run_cnt)
    );

    always #5 clock = ~clock;

    // Pair model: j counts edges since Start was sampled; A/E/F are derived from it.
    always @(posedge clock) begin
        if (start) j <= 0;
        else if (j < 200) j <= j + 1;
        if (start) startCount <= startCount + 1;
    end

    always_comb begin
        a_in = (j >= 13) ? 4'd13 : 4'(j);
        if (mode == 3 && j >= 5) a_in = (j >= 12) ? 4'd13 : 4'(j + 1);
        e_in = (j >= 13);
        f_in = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (j >= 14);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input int pairMode);
        mode = pairMode;
        @(negedge clock);
        go = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
        checkOutput({tag, "_start"}, start, 1);
        checkOutput({tag, "_busy"}, busy, 1);
    endtask

    task automatic waitDone(input string tag, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput({tag, "_done_seen"}, done, 1);
        if (done) begin
            @(posedge clock);
            #1;
            checkOutput({tag, "_done_pulse"}, done, 0);
            checkOutput({tag, "_busy_drop"}, busy, 0);
        end
    endtask

    task automatic checkRun(input string tag, input logic expPass, input logic expTo, input logic expStuck,
                            input logic [3:0] expA, input logic expE, input logic [7:0] expLat);
        checkOutput({tag, "_pass"}, pass, expPass);
        checkOutput({tag, "_timeout"}, timeout, expTo);
        checkOutput({tag, "_f_stuck"}, f_stuck, expStuck);
        checkOutput({tag, "_a_cap"}, a_cap, expA);
        checkOutput({tag, "_e_cap"}, e_cap, expE);
        checkOutput({tag, "_lat"}, lat, expLat);
    endtask

    initial begin
`ifdef CYCLE_CHECK_EN
        expSkipPass = 1'b0;
        expSkipSeq  = 1'b1;
`else
        expSkipPass = 1'b1;
        expSkipSeq  = 1'b0;
`endif
        reset = 1'b1;
        go    = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_seq_err", seq_err, 0);
        checkOutput("rst_run_cnt", run_cnt, 0);
        checkRun("rst", 0, 0, 0, 4'h0, 0, 8'd0);
        reset = 1'b0;

        $display("[TB] nominal run");
        s0 = startCount;
        applyStimulus("nom", 0);
        waitDone("nom", 40, edges);
        checkOutput("nom_edges", edges, 16);
        checkRun("nom", 1, 0, 0, 4'hD, 1, 8'd14);
        checkOutput("nom_seq_err", seq_err, 0);
        checkOutput("nom_run_cnt", run_cnt, 1);
        checkOutput("nom_start_pulses", startCount - s0, 1);

        $display("[TB] go while busy");
        s0 = startCount;
        applyStimulus("busy", 0);
        checkOutput("busy_pass_cleared", pass, 0);
        checkOutput("busy_lat_cleared", lat, 0);
        repeat (4) @(posedge clock);
        #1;
        go = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
        waitDone("busy", 40, edges);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("busy_run_cnt", run_cnt, 2);
        checkOutput("busy_start_pulses", startCount - s0, 1);
        checkOutput("busy_idle", busy, 0);

        $display("[TB] timeout");
        applyStimulus("to", 1);
        waitDone("to", 40, edges);
        checkOutput("to_edges", edges, 21);
        checkRun("to", 0, 1, 0, 4'h0, 0, 8'd20);
        checkOutput("to_seq_err", seq_err, 0);

        $display("[TB] F stuck high");
        applyStimulus("stk", 2);
        waitDone("stk", 40, edges);
        checkOutput("stk_edges", edges, 2);
        checkRun("stk", 0, 0, 1, 4'h0, 0, 8'd0);

        $display("[TB] A sequence skip");
        applyStimulus("skip", 3);
        waitDone("skip", 40, edges);
        checkOutput("skip_edges", edges, 16);
        checkRun("skip", expSkipPass, 0, 0, 4'hD, 1, 8'd14);
        checkOutput("skip_seq_err", seq_err, expSkipSeq);

        $display("[TB] reset mid-run");
        applyStimulus("mid", 0);
        repeat (6) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid_start", start, 0);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_done", done, 0);
        checkOutput("mid_run_cnt", run_cnt, 0);
        checkOutput("mid_seq_err", seq_err, 0);
        checkRun("mid", 0, 0, 0, 4'h0, 0, 8'd0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus("after", 0);
        waitDone("after", 40, edges);
        checkOutput("after_edges", edges, 16);
        checkRun("after", 1, 0, 0, 4'hD, 1, 8'd14);
        checkOutput("after_run_cnt", run_cnt, 1);

        $display("[TB] back-to-back");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mode = 0;
        s0 = startCount;
        nDone = 0;
        go = 1'b1;
        for (int n = 0; n < 60 && nDone < 2; n++) begin
            @(posedge clock);
            #1;
            if (done) begin
                nDone++;
                checkOutput("b2b_pass", pass, 1);
                checkOutput("b2b_lat", lat, 14);
                if (nDone == 2) go = 1'b0;
            end
        end
        go = 1'b0;
        checkOutput("b2b_done_count", nDone, 2);
        checkOutput("b2b_run_cnt", run_cnt, 2);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("b2b_start_pulses", startCount - s0, 2);
        checkOutput("b2b_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
